// File: rtl/ysyx_24120013_operand_fetch_if.sv
// ysyx_24120013_operand_fetch_if: bundle of the operand-fetch stage buses.
//   in_*      : instruction handshake from decode (in_valid/in_ready, in_inst, in_pc)
//   rf_*      : register file synchronous read ports (address out, data back next cycle)
//   wb_*      : writeback write port observed for forwarding
//   flush     : discard the held instruction
//   out_*     : operand handshake to execute (out_valid/out_ready, pc, inst, rd, rs values, imm)
//   slave     : view taken by the operand-fetch stage
//   master    : view taken by the surrounding pipeline / bench
interface ysyx_24120013_operand_fetch_if #(
    parameter int RF_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              in_inst;
    logic [DATA_WIDTH-1:0]    in_pc;
    logic [RF_ADDR_WIDTH-1:0] rf_raddr1;
    logic [RF_ADDR_WIDTH-1:0] rf_raddr2;
    logic [DATA_WIDTH-1:0]    rf_rdata1;
    logic [DATA_WIDTH-1:0]    rf_rdata2;
    logic                     wb_wen;
    logic [RF_ADDR_WIDTH-1:0] wb_waddr;
    logic [DATA_WIDTH-1:0]    wb_wdata;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    out_pc;
    logic [31:0]              out_inst;
    logic [RF_ADDR_WIDTH-1:0] out_rd;
    logic [DATA_WIDTH-1:0]    out_rs1_val;
    logic [DATA_WIDTH-1:0]    out_rs2_val;
    logic [DATA_WIDTH-1:0]    out_imm;

    modport slave (
        input  in_valid, in_inst, in_pc, rf_rdata1, rf_rdata2,
               wb_wen, wb_waddr, wb_wdata, flush, out_ready,
        output in_ready, rf_raddr1, rf_raddr2, out_valid, out_pc,
               out_inst, out_rd, out_rs1_val, out_rs2_val, out_imm
    );

    modport master (
        output in_valid, in_inst, in_pc, rf_rdata1, rf_rdata2,
               wb_wen, wb_waddr, wb_wdata, flush, out_ready,
        input  in_ready, rf_raddr1, rf_raddr2, out_valid, out_pc,
               out_inst, out_rd, out_rs1_val, out_rs2_val, out_imm
    );
endinterface

// File: rtl/ysyx_24120013_operand_fetch.sv
// ysyx_24120013_operand_fetch: operand-fetch stage ahead of a synchronous-read register file.
//   clk   : clock, all state on posedge
//   rst   : synchronous active-high reset
//   of_io : slave view of ysyx_24120013_operand_fetch_if (instruction in, rf read ports,
//           writeback snoop, flush, operands out to execute)
module ysyx_24120013_operand_fetch #(
    parameter int RF_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input logic                          clk,
    input logic                          rst,
    ysyx_24120013_operand_fetch_if.slave of_io
);
    localparam int AW = RF_ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

    state_t        state_q;
    logic [31:0]   inst_q;
    logic [DW-1:0] pc_q;
    logic          fwd1_q, fwd2_q;
    logic [DW-1:0] fwd1_data_q, fwd2_data_q;
    logic [AW-1:0] rs1, rs2;
    logic          accept;
    logic [31:0]   imm32;
    logic [6:0]    op;

    assign rs1 = inst_q[15 +: AW];
    assign rs2 = inst_q[20 +: AW];
    assign op  = inst_q[6:0];

    assign of_io.in_ready = !rst && !of_io.flush &&
                            (state_q == IDLE || (state_q == VALID && of_io.out_ready));
    assign accept = of_io.in_valid && of_io.in_ready;

    // Read addresses come from the held instruction so the file sees a stable address.
    assign of_io.rf_raddr1 = rs1;
    assign of_io.rf_raddr2 = rs2;

    always_comb begin
        imm32 = (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111 || op == 7'b1110011)
                    ? {{20{inst_q[31]}}, inst_q[31:20]} :
                (op == 7'b0100011) ? {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]} :
                (op == 7'b1100011) ? {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25],
                                      inst_q[11:8], 1'b0} :
                (op == 7'b0110111 || op == 7'b0010111) ? {inst_q[31:12], 12'b0} :
                (op == 7'b1101111) ? {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20],
                                      inst_q[30:21], 1'b0} :
                32'b0;
    end

    assign of_io.out_valid   = !rst && state_q == VALID;
    assign of_io.out_pc      = rst ? '0 : pc_q;
    assign of_io.out_inst    = rst ? '0 : inst_q;
    assign of_io.out_rd      = rst ? '0 : inst_q[7 +: AW];
    assign of_io.out_imm     = rst ? '0 : DW'($signed(imm32));
    assign of_io.out_rs1_val = (rst || rs1 == '0) ? '0 : fwd1_q ? fwd1_data_q : of_io.rf_rdata1;
    assign of_io.out_rs2_val = (rst || rs2 == '0) ? '0 : fwd2_q ? fwd2_data_q : of_io.rf_rdata2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            inst_q      <= '0;
            pc_q        <= '0;
            fwd1_q      <= 1'b0;
            fwd2_q      <= 1'b0;
            fwd1_data_q <= '0;
            fwd2_data_q <= '0;
        end else begin
            // The file's read at this edge misses a write committed at the same edge.
            if (state_q != IDLE) begin
                fwd1_q      <= of_io.wb_wen && of_io.wb_waddr == rs1 && rs1 != '0;
                fwd2_q      <= of_io.wb_wen && of_io.wb_waddr == rs2 && rs2 != '0;
                fwd1_data_q <= of_io.wb_wdata;
                fwd2_data_q <= of_io.wb_wdata;
            end
            if (accept) begin
                inst_q <= of_io.in_inst;
                pc_q   <= of_io.in_pc;
            end
            if (of_io.flush) state_q <= IDLE;
            else begin
                case (state_q)
                    IDLE:    state_q <= accept ? FETCH : IDLE;
                    FETCH:   state_q <= VALID;
                    VALID:   state_q <= of_io.out_ready ? (accept ? FETCH : IDLE) : VALID;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ysyx_24120013_operand_fetch.sv
// tb_ysyx_24120013_operand_fetch: directed bench with a synchronous-read register file model.
module tb_ysyx_24120013_operand_fetch;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ysyx_24120013_operand_fetch_if #(.RF_ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    ysyx_24120013_operand_fetch #(.RF_ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .of_io (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file: read returns pre-edge contents, so a same-edge write is missed.
    logic [31:0] regs [32] = '{default: 32'h0};
    always @(posedge clk) begin
        if (bus.wb_wen && bus.wb_waddr != 5'd0) regs[bus.wb_waddr] <= bus.wb_wdata;
        bus.rf_rdata1 <= regs[bus.rf_raddr1];
        bus.rf_rdata2 <= regs[bus.rf_raddr2];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid = 0; bus.in_inst = 0; bus.in_pc = 0;
        bus.wb_wen = 0; bus.wb_waddr = 0; bus.wb_wdata = 0;
        bus.flush = 0; bus.out_ready = 0;
        tick();
        tick();
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rel_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rel_raddr1", {27'b0, bus.rf_raddr1}, 32'd0);
        chk("rel_raddr2", {27'b0, bus.rf_raddr2}, 32'd0);

        bus.wb_wen = 1; bus.wb_waddr = 1; bus.wb_wdata = 32'd5;
        tick();
        bus.wb_waddr = 2; bus.wb_wdata = 32'd7;
        tick();
        bus.wb_wen = 0;

        // add x3,x1,x2
        bus.in_valid = 1; bus.in_inst = 32'h002081B3; bus.in_pc = 32'h80000000; bus.out_ready = 1;
        #1;
        chk("add_in_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 0;
        chk("add_fetch_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("add_raddr1", {27'b0, bus.rf_raddr1}, 32'd1);
        chk("add_raddr2", {27'b0, bus.rf_raddr2}, 32'd2);
        tick();
        chk("add_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("add_rs1", bus.out_rs1_val, 32'd5);
        chk("add_rs2", bus.out_rs2_val, 32'd7);
        chk("add_rd", {27'b0, bus.out_rd}, 32'd3);
        chk("add_pc", bus.out_pc, 32'h80000000);
        chk("add_imm", bus.out_imm, 32'd0);
        tick();
        chk("add_done", {31'b0, bus.out_valid}, 32'd0);

        // writeback of x1 during FETCH must be forwarded
        bus.in_valid = 1; bus.in_pc = 32'h80000004;
        tick();
        bus.in_valid = 0;
        bus.wb_wen = 1; bus.wb_waddr = 1; bus.wb_wdata = 32'h11;
        tick();
        bus.wb_wen = 0;
        chk("fwd_rs1", bus.out_rs1_val, 32'h11);
        chk("fwd_rs2", bus.out_rs2_val, 32'd7);
        tick();

        // add x3,x0,x2 with a write to x0 during FETCH
        bus.in_valid = 1; bus.in_inst = 32'h002001B3;
        tick();
        bus.in_valid = 0;
        bus.wb_wen = 1; bus.wb_waddr = 0; bus.wb_wdata = 32'hDEAD;
        tick();
        bus.wb_wen = 0;
        chk("x0_rs1", bus.out_rs1_val, 32'd0);
        chk("x0_rs2", bus.out_rs2_val, 32'd7);
        tick();

        // stall with writeback of x2 during VALID
        bus.in_valid = 1; bus.in_inst = 32'h002081B3; bus.out_ready = 0;
        tick();
        bus.in_valid = 0;
        tick();
        chk("stall_valid0", {31'b0, bus.out_valid}, 32'd1);
        chk("stall_rs1", bus.out_rs1_val, 32'h11);
        chk("stall_rs2_pre", bus.out_rs2_val, 32'd7);
        bus.wb_wen = 1; bus.wb_waddr = 2; bus.wb_wdata = 32'h22;
        tick();
        bus.wb_wen = 0;
        chk("stall_rs2_fwd", bus.out_rs2_val, 32'h22);
        chk("stall_valid1", {31'b0, bus.out_valid}, 32'd1);
        tick();
        chk("stall_rs2_rf", bus.out_rs2_val, 32'h22);
        chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("stall_pc", bus.out_pc, 32'h80000004);
        bus.out_ready = 1;
        tick();
        chk("stall_release", {31'b0, bus.out_valid}, 32'd0);

        // back-to-back immediates: lui, addi -1, jal -4
        bus.in_valid = 1; bus.in_inst = 32'h123452B7;
        tick();
        chk("b2b_fetch0", {31'b0, bus.out_valid}, 32'd0);
        bus.in_inst = 32'hFFF00093;
        tick();
        chk("lui_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("lui_imm", bus.out_imm, 32'h12345000);
        chk("lui_rd", {27'b0, bus.out_rd}, 32'd5);
        chk("b2b_in_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        chk("b2b_fetch1", {31'b0, bus.out_valid}, 32'd0);
        bus.in_inst = 32'hFFDFF06F;
        tick();
        chk("addi_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("addi_imm", bus.out_imm, 32'hFFFFFFFF);
        chk("addi_rd", {27'b0, bus.out_rd}, 32'd1);
        chk("addi_rs1", bus.out_rs1_val, 32'd0);
        tick();
        bus.in_valid = 0;
        chk("b2b_fetch2", {31'b0, bus.out_valid}, 32'd0);
        tick();
        chk("jal_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("jal_imm", bus.out_imm, 32'hFFFFFFFC);
        chk("jal_rd", {27'b0, bus.out_rd}, 32'd0);
        tick();

        // flush in VALID
        bus.in_valid = 1; bus.in_inst = 32'h002081B3;
        tick();
        bus.in_valid = 0;
        tick();
        chk("fl_valid", {31'b0, bus.out_valid}, 32'd1);
        bus.out_ready = 0; bus.flush = 1;
        #1;
        chk("fl_in_ready", {31'b0, bus.in_ready}, 32'd0);
        tick();
        chk("fl_after", {31'b0, bus.out_valid}, 32'd0);
        bus.flush = 0;
        #1;
        chk("fl_idle_ready", {31'b0, bus.in_ready}, 32'd1);

        // flush in IDLE blocks an offered instruction
        bus.flush = 1; bus.in_valid = 1; bus.in_inst = 32'h123452B7;
        tick();
        bus.flush = 0; bus.in_valid = 0;
        tick();
        chk("fl_no_accept", {31'b0, bus.out_valid}, 32'd0);
        chk("fl_inst_kept", bus.out_inst, 32'h002081B3);

        // mid-operation reset drops the in-flight instruction
        bus.out_ready = 1; bus.in_valid = 1; bus.in_inst = 32'hFFF00093;
        tick();
        bus.in_valid = 0;
        rst = 1;
        #1;
        chk("mrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("mrst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("mrst_inst_zero", bus.out_inst, 32'd0);
        tick();
        rst = 0;
        tick();
        chk("mrst_after_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("mrst_after_inst", bus.out_inst, 32'd0);
        chk("mrst_after_raddr1", {27'b0, bus.rf_raddr1}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
